// File: rtl/stopwatch_count_core.sv
// stopwatch_count_core
// Sequential core of an MM:SS stopwatch: four registered BCD digits and a
// run-control FSM (IDLE/RUN/PAUSE/DONE). Counts up or down on tick while
// running. Every output is registered.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   tick          one-cycle count enable (1 Hz time base)
//   start_stop    one-cycle pulse, toggles run/pause
//   clear         synchronous clear to 00:00 and IDLE
//   load          one-cycle pulse, loads preset_digits
//   dir           0 = count up, 1 = count down
//   preset_digits {min_tens, min_units, sec_tens, sec_units}
//   digits        current count, same packing as preset_digits
//   running       high in RUN
//   paused        high in PAUSE
//   zero          high when digits == 0
//   wrap          pulse on up-count 59:59 -> 00:00
//   done          pulse when a down-count reaches 00:00
//   load_err      pulse when a load carries an out-of-range digit
module stopwatch_count_core #(
  parameter int unsigned SEC_TENS_MAX = 5,
  parameter int unsigned UNITS_MAX    = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic        dir,
  input  logic [15:0] preset_digits,
  output logic [15:0] digits,
  output logic        running,
  output logic        paused,
  output logic        zero,
  output logic        wrap,
  output logic        done,
  output logic        load_err
);

  localparam logic [3:0] UMAX = 4'(UNITS_MAX);
  localparam logic [3:0] TMAX = 4'(SEC_TENS_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] digits_nxt;
  logic        wrap_nxt, done_nxt, err_nxt;

  // Per-digit increment: {carry_out, new_digit}. Carry only when enabled
  // and the digit sits at (or above) its maximum.
  function automatic logic [4:0] inc_digit(input logic [3:0] d,
                                           input logic [3:0] maxv,
                                           input logic       en);
    if (!en)        return {1'b0, d};
    if (d >= maxv)  return {1'b1, 4'h0};
    return {1'b0, d + 4'd1};
  endfunction

  // Per-digit decrement: {borrow_out, new_digit}.
  function automatic logic [4:0] dec_digit(input logic [3:0] d,
                                           input logic [3:0] maxv,
                                           input logic       en);
    if (!en)        return {1'b0, d};
    if (d == 4'h0)  return {1'b1, maxv};
    return {1'b0, d - 4'd1};
  endfunction

  logic [15:0] up_digits, dn_digits;
  logic        c1, c2, c3, c4;
  logic        b1, b2, b3;
  logic        preset_ok;

  always_comb begin
    {c1, up_digits[3:0]}   = inc_digit(digits[3:0],   UMAX, 1'b1);
    {c2, up_digits[7:4]}   = inc_digit(digits[7:4],   TMAX, c1);
    {c3, up_digits[11:8]}  = inc_digit(digits[11:8],  UMAX, c2);
    {c4, up_digits[15:12]} = inc_digit(digits[15:12], TMAX, c3);

    {b1, dn_digits[3:0]}   = dec_digit(digits[3:0],   UMAX, 1'b1);
    {b2, dn_digits[7:4]}   = dec_digit(digits[7:4],   TMAX, b1);
    {b3, dn_digits[11:8]}  = dec_digit(digits[11:8],  UMAX, b2);
    // Top borrow is never needed: a down-tick at 00:00 is suppressed.
    if (b3) dn_digits[15:12] = (digits[15:12] == 4'h0) ? TMAX : digits[15:12] - 4'd1;
    else    dn_digits[15:12] = digits[15:12];

    preset_ok = (preset_digits[3:0]   <= UMAX) && (preset_digits[7:4]   <= TMAX) &&
                (preset_digits[11:8]  <= UMAX) && (preset_digits[15:12] <= TMAX);
  end

  // Next-state decision. A load in RUN is treated as absent, so lower
  // priority start_stop/tick still act that cycle.
  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    wrap_nxt   = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    if (clear) begin
      state_nxt  = IDLE;
      digits_nxt = '0;
    end else if (load && state != RUN) begin
      if (preset_ok) begin
        state_nxt  = IDLE;
        digits_nxt = preset_digits;
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (start_stop && !(dir && zero)) state_nxt = RUN;
        end
        RUN: begin
          if (tick) begin
            if (!dir) begin
              digits_nxt = up_digits;
              wrap_nxt   = c4;
            end else if (!zero) begin
              digits_nxt = dn_digits;
              done_nxt   = (dn_digits == 16'h0000);
            end
          end
          // Reaching 00:00 wins over a simultaneous pause request.
          if (done_nxt)        state_nxt = DONE;
          else if (start_stop) state_nxt = PAUSE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      digits   <= '0;
      running  <= 1'b0;
      paused   <= 1'b0;
      zero     <= 1'b1;
      wrap     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      digits   <= digits_nxt;
      running  <= (state_nxt == RUN);
      paused   <= (state_nxt == PAUSE);
      zero     <= (digits_nxt == 16'h0000);
      wrap     <= wrap_nxt;
      done     <= done_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_count_core.sv
// Self-checking bench for stopwatch_count_core: reset checks, a vector
// table, hand-written corner sequences and a randomized run against a
// seconds-based reference model.
module tb_stopwatch_count_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
  logic [15:0] preset_digits = '0;
  logic [15:0] digits;
  logic        running, paused, zero, wrap, done, load_err;

  int checks = 0;
  int errors = 0;

  stopwatch_count_core #(.SEC_TENS_MAX(5), .UNITS_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .clear(clear), .load(load), .dir(dir), .preset_digits(preset_digits),
    .digits(digits), .running(running), .paused(paused), .zero(zero),
    .wrap(wrap), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed time as a plain seconds count, state as an int
  // (0 idle, 1 run, 2 pause, 3 done).
  int m_secs = 0;
  int m_st   = 0;
  bit m_wrap = 0, m_done = 0, m_err = 0;

  function automatic bit valid_preset(input logic [15:0] p);
    return p[3:0] <= 9 && p[7:4] <= 5 && p[11:8] <= 9 && p[15:12] <= 5;
  endfunction

  function automatic int to_secs(input logic [15:0] p);
    return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

  function automatic logic [15:0] to_digits(input int s);
    int m, sec;
    m = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  task automatic model_step(input bit c, input bit ld, input bit ss, input bit tk,
                            input bit dr, input logic [15:0] pre);
    m_wrap = 0; m_done = 0; m_err = 0;
    if (c) begin
      m_secs = 0; m_st = 0;
    end else if (ld && m_st != 1) begin
      if (valid_preset(pre)) begin m_secs = to_secs(pre); m_st = 0; end
      else m_err = 1;
    end else if (m_st == 1) begin
      if (tk) begin
        if (!dr) begin
          m_secs = (m_secs + 1) % 3600;
          m_wrap = (m_secs == 0);
        end else if (m_secs > 0) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_done = 1; m_st = 3; end
        end
      end
      if (m_st == 1 && ss) m_st = 2;
    end else if ((m_st == 0 || m_st == 2) && ss && !(dr && m_secs == 0)) begin
      m_st = 1;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ed, input bit er,
                         input bit ep, input bit ew, input bit edn, input bit ee);
    chk({tag, ".digits"},   int'(digits),   int'(ed));
    chk({tag, ".running"},  int'(running),  int'(er));
    chk({tag, ".paused"},   int'(paused),   int'(ep));
    chk({tag, ".zero"},     int'(zero),     int'(ed == 16'h0000));
    chk({tag, ".wrap"},     int'(wrap),     int'(ew));
    chk({tag, ".done"},     int'(done),     int'(edn));
    chk({tag, ".load_err"}, int'(load_err), int'(ee));
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input bit c, input bit ld, input bit ss, input bit tk,
                      input bit dr, input logic [15:0] pre);
    clear = c; load = ld; start_stop = ss; tick = tk; dir = dr; preset_digits = pre;
    model_step(c, ld, ss, tk, dr, pre);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, to_digits(m_secs), m_st == 1, m_st == 2, m_wrap, m_done, m_err);
  endtask

  typedef struct {
    bit c, ld, ss, tk, dr;
    logic [15:0] pre;
    logic [15:0] ed;
    bit er, ep, ew, edn, ee;
  } vec_t;

  function automatic vec_t mk(input bit c, input bit ld, input bit ss, input bit tk,
                              input bit dr, input logic [15:0] pre, input logic [15:0] ed,
                              input bit er, input bit ep, input bit ew, input bit edn,
                              input bit ee);
    vec_t v;
    v.c = c; v.ld = ld; v.ss = ss; v.tk = tk; v.dr = dr; v.pre = pre;
    v.ed = ed; v.er = er; v.ep = ep; v.ew = ew; v.edn = edn; v.ee = ee;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Starts from IDLE, 00:00. Columns: clr ld ss tk dr pre | digits run pau wrap done err
    tbl.push_back(mk(0,1,0,0,0,16'h0A00, 16'h0000,0,0,0,0,1)); // bad units digit
    tbl.push_back(mk(0,0,0,0,0,16'h0000, 16'h0000,0,0,0,0,0)); // err is one cycle
    tbl.push_back(mk(0,1,0,0,0,16'h6000, 16'h0000,0,0,0,0,1)); // bad tens digit
    tbl.push_back(mk(0,1,0,0,0,16'h0130, 16'h0130,0,0,0,0,0)); // accepted
    tbl.push_back(mk(0,0,1,0,0,16'h0000, 16'h0130,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,1,0,16'h0A00, 16'h0131,1,0,0,0,0)); // load ignored in RUN
    tbl.push_back(mk(0,0,1,1,0,16'h0000, 16'h0132,0,1,0,0,0)); // tick then pause
    tbl.push_back(mk(0,0,0,1,0,16'h0000, 16'h0132,0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,16'h0000, 16'h0132,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,16'h0000, 16'h0000,0,0,0,0,0)); // clear in RUN
    tbl.push_back(mk(0,0,1,0,1,16'h0000, 16'h0000,0,0,0,0,0)); // down at zero: stay IDLE
    tbl.push_back(mk(0,1,0,0,1,16'h0001, 16'h0001,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,16'h0000, 16'h0001,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1,16'h0000, 16'h0000,0,0,0,1,0)); // reaches DONE
    tbl.push_back(mk(0,0,1,1,1,16'h0000, 16'h0000,0,0,0,0,0)); // DONE ignores
    tbl.push_back(mk(0,1,0,0,0,16'h9999, 16'h0000,0,0,0,0,1)); // rejected in DONE
    tbl.push_back(mk(0,1,0,0,0,16'h0005, 16'h0005,0,0,0,0,0)); // accepted in DONE

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 16'h0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_secs = 0; m_st = 0;

    // Table vectors
    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].ld, tbl[i].ss, tbl[i].tk, tbl[i].dr, tbl[i].pre);
      chk_all($sformatf("vec%0d", i), tbl[i].ed, tbl[i].er, tbl[i].ep, tbl[i].ew,
              tbl[i].edn, tbl[i].ee);
    end

    // Ten up-ticks from 00:00
    step(1,0,0,0,0,16'h0);
    step(0,0,1,0,0,16'h0);
    for (int i = 0; i < 10; i++) step(0,0,0,1,0,16'h0);
    chk_all("up10", 16'h0010, 1, 0, 0, 0, 0);

    // Wrap at 59:59
    step(1,0,0,0,0,16'h0);
    step(0,1,0,0,0,16'h5958);
    step(0,0,1,0,0,16'h0);
    step(0,0,0,1,0,16'h0);
    chk_all("wrap.a", 16'h5959, 1, 0, 0, 0, 0);
    step(0,0,0,1,0,16'h0);
    chk_all("wrap.b", 16'h0000, 1, 0, 1, 0, 0);
    step(0,0,0,0,0,16'h0);
    chk_all("wrap.c", 16'h0000, 1, 0, 0, 0, 0);

    // Down-count to DONE
    step(0,0,1,0,0,16'h0);
    step(0,1,0,0,1,16'h0002);
    step(0,0,1,0,1,16'h0);
    step(0,0,0,1,1,16'h0);
    chk_all("down.a", 16'h0001, 1, 0, 0, 0, 0);
    step(0,0,0,1,1,16'h0);
    chk_all("down.b", 16'h0000, 0, 0, 0, 1, 0);
    step(0,0,1,1,1,16'h0);
    step(0,0,0,1,1,16'h0);
    chk_all("down.c", 16'h0000, 0, 0, 0, 0, 0);

    // Pause with simultaneous tick at 00:05
    step(0,1,0,0,0,16'h0005);
    step(0,0,1,0,0,16'h0);
    step(0,0,1,1,0,16'h0);
    chk_all("pause.a", 16'h0006, 0, 1, 0, 0, 0);
    step(0,0,0,1,0,16'h0);
    step(0,0,0,1,0,16'h0);
    chk_all("pause.b", 16'h0006, 0, 1, 0, 0, 0);

    // Direction change mid-run applies on the next tick
    step(0,0,1,0,0,16'h0);
    step(0,0,0,0,1,16'h0);
    chk_all("dir.a", 16'h0006, 1, 0, 0, 0, 0);
    step(0,0,0,1,1,16'h0);
    chk_all("dir.b", 16'h0005, 1, 0, 0, 0, 0);

    // Asynchronous reset mid-run at 12:34
    step(1,0,0,0,0,16'h0);
    step(0,1,0,0,0,16'h1234);
    step(0,0,1,0,0,16'h0);
    chk_all("arst.pre", 16'h1234, 1, 0, 0, 0, 0);
    tick = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_all("arst.now", 16'h0000, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    m_secs = 0; m_st = 0;
    step(0,0,0,1,0,16'h0);
    chk_all("arst.after", 16'h0000, 0, 0, 0, 0, 0);

    // Clear in RUN
    step(0,1,0,0,0,16'h0100);
    step(0,0,1,0,0,16'h0);
    step(0,0,0,1,0,16'h0);
    step(1,0,0,1,0,16'h0);
    chk_all("clear", 16'h0000, 0, 0, 0, 0, 0);

    // Randomized run against the model
    begin
      bit dr = 0;
      for (int i = 0; i < 4000; i++) begin
        bit c, ld, ss, tk;
        logic [15:0] pre;
        int r;
        if ($urandom_range(0, 19) == 0) dr = ~dr;
        c  = ($urandom_range(0, 99) == 0);
        ld = ($urandom_range(0, 29) == 0);
        ss = ($urandom_range(0, 11) == 0);
        tk = ($urandom_range(0, 9) < 6);
        r  = $urandom_range(0, 9);
        if (r < 4)      pre = to_digits($urandom_range(0, 20));
        else if (r < 5) pre = to_digits($urandom_range(3590, 3599));
        else if (r < 8) pre = to_digits($urandom_range(0, 3599));
        else            pre = 16'($urandom);
        step(c, ld, ss, tk, dr, pre);
        chk_model("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
